mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline.
- Consumes the execute-stage result (address or ALU value, store data, opcode) and performs loads and stores against a single-port data memory using a req/gnt/rvalid handshake.
- Sign- or zero-extends load data and presents a registered result to writeback.
- Non-memory ops pass through in one cycle.

Parameters:
- N, 32, data/address width.
- TIMEOUT, 16, max cycles waiting for gnt or rvalid before an error is raised.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  stage can accept an execute result this cycle.
- ex_opcode  in  7  opcode (riscv_pkg OPCODE_*).
- ex_funct3  in  3  access size/sign.
- ex_rd  in  5  destination register.
- ex_alu_result  in  N  ALU result, or effective address for load/store.
- ex_rs2_data  in  N  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  N  word-aligned address ({addr[N-1:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  N  lane-shifted store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  N  read data.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  5  destination register.
- wb_data  out  N  writeback data.
- wb_we  out  1  register write enable.
- wb_exc  out  2  0 none, 1 misaligned, 2 timeout.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_exc=0, dmem_req=0, timeout counter 0. Reset mid-transaction abandons the access; a late gnt or rvalid after reset is ignored.
- Output register: occupied when wb_valid=1. It drains on wb_valid&&wb_ready.
- ex_ready = (state==IDLE) && (!wb_valid || wb_ready).
- Accept = ex_valid && ex_ready.
- States: IDLE, REQ, RSP.
- IDLE, accepted non-memory op:
  - Next cycle wb_valid=1, wb_data=ex_alu_result.
  - wb_we=1 except OPCODE_BRANCH, OPCODE_STORE, or rd==0.
  - Latency 1.
- IDLE, accepted load/store:
  - Latch address, data, funct3, rd.
  - Misaligned (halfword addr[0]!=0; word addr[1:0]!=0): no memory access; next cycle wb_valid=1, wb_exc=1, wb_we=0.
  - Otherwise go to REQ with dmem_req=1 from the next cycle.
- REQ:
  - dmem_req, dmem_we, addr, be, wdata all held stable until gnt.
  - On gnt: dmem_req drops the following cycle.
  - Store + gnt: complete; wb_valid=1 next cycle, wb_we=0; back to IDLE.
  - Load + gnt: go to RSP.
- RSP: on rvalid, extract the lane and extend, then wb_valid=1, wb_we=(rd!=0); back to IDLE.
- Minimum latencies: store 2 cycles, load 3 cycles (gnt and rvalid each in the earliest cycle).
- gnt and rvalid in the same cycle as the request are treated in order: gnt is consumed in REQ; rvalid is only sampled in RSP.
- Byte enables:
  - SB: be=4'b0001<<addr[1:0], wdata=rs2 byte replicated across all lanes.
  - SH: be=4'b0011<<addr[1:0], wdata=rs2 halfword replicated.
  - SW: be=4'b1111.
- Load extract: LB/LBU select byte addr[1:0], LH/LHU select halfword addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Unsupported funct3 on load/store: treated as misaligned (wb_exc=1).
- Timeout:
  - Counter clears on entry to REQ and RSP and increments each cycle waiting.
  - On reaching TIMEOUT: drop req, wb_valid=1, wb_exc=2, wb_we=0, return to IDLE.
- Back-pressure: while wb_valid && !wb_ready, the output register holds and ex_ready=0.

Decomposition:
- Package riscv_pkg (existing) holds OPCODE_*. Add to it:
  - F3_LB/LH/LW/LBU/LHU/SB/SH/SW constants.
  - typedef enum mem_state_e {IDLE,REQ,RSP}.
  - typedef enum mem_exc_e {EXC_NONE,EXC_MISALIGN,EXC_TIMEOUT}.
- Sub-module load_align: combinational lane select and sign/zero extend (rdata, addr[1:0], funct3 -> data).

Test Plan:
- ADD result 0x0000_1234, rd=5, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_we=1, dmem_req stays 0.
- SB addr=0x103, rs2=0xAB, gnt in first REQ cycle -> dmem_be=4'b1000, dmem_addr=0x100, wdata=0xABABABAB; wb_valid 2 cycles after accept, wb_we=0.
- LB addr=0x102, rdata=0x0080_0000 after 2 wait cycles -> wb_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LW addr=0x102 -> no dmem_req, wb_exc=1, wb_we=0, ex_ready high again next cycle.
- Load with gnt never asserted, TIMEOUT=16 -> wb_exc=2 after 16 REQ cycles, dmem_req deasserted.
- Load in RSP, rst_n low one cycle, then rvalid -> wb_valid stays 0, state IDLE, ex_ready=1; wb_ready=0 with held result -> ex_ready=0 and wb_data stable until wb_ready.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V pipeline definitions.
//   OPCODE_*   major opcodes (inst[6:0])
//   F3_*       load/store funct3 encodings
//   mem_state_e, mem_exc_e   memory-stage FSM state and exception code
//   mem_access_ok()          size/alignment legality of a load or store
package riscv_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2
    } mem_exc_e;

    // Unsupported funct3 values report as illegal, same as a misaligned access.
    function automatic logic mem_access_ok(input logic [2:0] f3,
                                           input logic [1:0] a,
                                           input logic       store);
        logic ok;
        ok = 1'b0;
        if (store) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = !a[0];
                F3_SW:   ok = (a == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = !a[0];
                F3_LW:         ok = (a == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: single-port data memory bus with req/gnt/rvalid handshake.
//   master (pipeline): req, we, addr, be, wdata out; gnt, rvalid, rdata in
//   slave  (memory)  : the reverse
interface mem_stage_if #(
    parameter int unsigned N = 32
) ();
    logic         req;
    logic         we;
    logic [N-1:0] addr;
    logic [3:0]   be;
    logic [N-1:0] wdata;
    logic         gnt;
    logic         rvalid;
    logic [N-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load lane select and sign/zero extension.
//   rdata_i  raw word from memory
//   addr_i   low address bits selecting the byte/halfword lane
//   funct3_i LB/LH/LW/LBU/LHU
//   data_o   extended load result
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] rdata_i,
    input  logic [1:0]   addr_i,
    input  logic [2:0]   funct3_i,
    output logic [N-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(N-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(N-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(N-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(N-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RISC-V pipeline.
//   clk, rst_n        clock, synchronous active-low reset
//   ex_*              execute-stage result with valid/ready handshake
//   dmem              data memory bus (req/gnt/rvalid), master side
//   wb_*              registered result to writeback with valid/ready
//                     wb_exc: 0 none, 1 misaligned/illegal, 2 timeout
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_valid,
    output logic         ex_ready,
    input  logic [6:0]   ex_opcode,
    input  logic [2:0]   ex_funct3,
    input  logic [4:0]   ex_rd,
    input  logic [N-1:0] ex_alu_result,
    input  logic [N-1:0] ex_rs2_data,
    mem_stage_if.master  dmem,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [4:0]   wb_rd,
    output logic [N-1:0] wb_data,
    output logic         wb_we,
    output logic [1:0]   wb_exc
);
    localparam int unsigned   TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    mem_state_e    state_q;
    logic [TW-1:0] tcnt_q;
    logic          req_q, we_q;
    logic [N-1:0]  addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [2:0]    funct3_q;
    logic [4:0]    rd_q;
    logic          wb_valid_q, wb_we_q;
    logic [4:0]    wb_rd_q;
    logic [N-1:0]  wb_data_q;
    mem_exc_e      wb_exc_q;

    logic          accept, is_store, is_mem, access_ok;
    logic [3:0]    be_d;
    logic [N-1:0]  wdata_d, load_data;

    assign ex_ready  = (state_q == IDLE) && (!wb_valid_q || wb_ready);
    assign accept    = ex_valid && ex_ready;
    assign is_store  = (ex_opcode == OPCODE_STORE);
    assign is_mem    = is_store || (ex_opcode == OPCODE_LOAD);
    assign access_ok = mem_access_ok(ex_funct3, ex_alu_result[1:0], is_store);

    // Lane placement by access size; stores replicate the datum across lanes.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ex_alu_result[1:0];
                wdata_d = {(N/8){ex_rs2_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << ex_alu_result[1:0];
                wdata_d = {(N/16){ex_rs2_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = ex_rs2_data;
            end
        endcase
    end

    load_align #(.N(N)) u_load_align (
        .rdata_i  (dmem.rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= EXC_NONE;
        end else begin
            // Drain first; a result produced below in the same cycle overrides it.
            if (wb_valid_q && wb_ready) wb_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= ex_alu_result;
                        funct3_q <= ex_funct3;
                        rd_q     <= ex_rd;
                        wb_rd_q  <= ex_rd;
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= ex_alu_result;
                            wb_exc_q   <= EXC_NONE;
                            wb_we_q    <= !((ex_opcode == OPCODE_BRANCH) ||
                                            (ex_opcode == OPCODE_STORE) ||
                                            (ex_rd == 5'd0));
                        end else if (!access_ok) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= ex_alu_result;
                            wb_exc_q   <= EXC_MISALIGN;
                            wb_we_q    <= 1'b0;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            tcnt_q  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem.gnt) begin
                        req_q  <= 1'b0;
                        tcnt_q <= '0;
                        if (we_q) begin
                            state_q    <= IDLE;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            wb_exc_q   <= EXC_NONE;
                            wb_we_q    <= 1'b0;
                        end else begin
                            state_q <= RSP;
                        end
                    end else if (tcnt_q == TLAST) begin
                        state_q    <= IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= addr_q;
                        wb_exc_q   <= EXC_TIMEOUT;
                        wb_we_q    <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                RSP: begin
                    if (dmem.rvalid) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= load_data;
                        wb_exc_q   <= EXC_NONE;
                        wb_we_q    <= (rd_q != 5'd0);
                    end else if (tcnt_q == TLAST) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= addr_q;
                        wb_exc_q   <= EXC_TIMEOUT;
                        wb_we_q    <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = {addr_q[N-1:2], 2'b00};
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_we    = wb_we_q;
    assign wb_exc   = wb_exc_q;
endmodule
